// File: rtl/pe_noc_pkg.sv
// Shared NoC definitions: flit type ids, default field widths, packetizer state encoding
// and the flit packing helper used by the PE ports and the router.
package pe_noc_pkg;

    localparam int unsigned MESH_X       = 3;
    localparam int unsigned MESH_Y       = 3;
    localparam int unsigned X_SIZE       = $clog2(MESH_X);
    localparam int unsigned Y_SIZE       = $clog2(MESH_Y);
    localparam int unsigned ID_WIDTH     = 2;
    localparam int unsigned DATA_WIDTH   = 24;
    localparam int unsigned PKT_NO_WIDTH = 4;
    localparam int unsigned CNT_WIDTH    = 16;
    localparam int unsigned TOTAL_WIDTH  = X_SIZE + Y_SIZE + PKT_NO_WIDTH + ID_WIDTH + DATA_WIDTH;

    localparam logic [ID_WIDTH-1:0] FLIT_HEAD = 2'b00;
    localparam logic [ID_WIDTH-1:0] FLIT_BODY = 2'b01;
    localparam logic [ID_WIDTH-1:0] FLIT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHead = 2'd1,
        StBody = 2'd2,
        StTail = 2'd3
    } tx_state_e;

    function automatic logic [TOTAL_WIDTH-1:0] pack_flit(
        input logic [X_SIZE-1:0]       x,
        input logic [Y_SIZE-1:0]       y,
        input logic [PKT_NO_WIDTH-1:0] pkt_no,
        input logic [ID_WIDTH-1:0]     id,
        input logic [DATA_WIDTH-1:0]   data
    );
        return {x, y, pkt_no, id, data};
    endfunction

endpackage

// File: rtl/pe_packet_tx.sv
// PE injection packetizer: head flit, pix_count body flits, tail flit on a valid/ready port.
// Define PE_PACKET_TX_CHECKSUM_EN to carry the body payload sum in the tail instead of the count.
module pe_packet_tx
    import pe_noc_pkg::*;
#(
    parameter int unsigned X                 = MESH_X,
    parameter int unsigned Y                 = MESH_Y,
    parameter int unsigned id_width          = ID_WIDTH,
    parameter int unsigned data_width        = DATA_WIDTH,
    parameter int unsigned pkt_no_field_size = PKT_NO_WIDTH,
    parameter int unsigned cnt_width         = CNT_WIDTH,
    localparam int unsigned x_size           = $clog2(X),
    localparam int unsigned y_size           = $clog2(Y),
    localparam int unsigned total_width      = x_size + y_size + pkt_no_field_size + id_width
                                               + data_width
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [x_size-1:0]      dst_x,
    input  logic [y_size-1:0]      dst_y,
    input  logic [cnt_width-1:0]   pix_count,
    input  logic [data_width-1:0]  head_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [data_width-1:0]  pix_data,
    output logic                   w_valid_pe,
    input  logic                   w_ready_pe,
    output logic [total_width-1:0] w_data_pe,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_monitor
);

    tx_state_e                    state_q, state_d;
    logic                         out_valid_q, out_valid_d;
    logic [total_width-1:0]       out_data_q, out_data_d;
    logic [x_size-1:0]            dst_x_q, dst_x_d;
    logic [y_size-1:0]            dst_y_q, dst_y_d;
    logic [cnt_width-1:0]         count_q, count_d;
    logic [cnt_width-1:0]         sent_q, sent_d;
    logic [pkt_no_field_size-1:0] pkt_no_q, pkt_no_d;
    logic                         done_q, done_d;
    logic [data_width-1:0]        tail_payload;
    logic                         out_free, out_hs, pix_left, pix_take;

    function automatic logic [total_width-1:0] make_flit(
        input logic [x_size-1:0]            x,
        input logic [y_size-1:0]            y,
        input logic [pkt_no_field_size-1:0] pkt_no,
        input logic [1:0]                   id,
        input logic [data_width-1:0]        data
    );
        return {x, y, pkt_no, id_width'(id), data};
    endfunction

`ifdef PE_PACKET_TX_CHECKSUM_EN
    logic [data_width-1:0] acc_q, acc_d;
    assign tail_payload = acc_q;
`else
    assign tail_payload = data_width'(count_q);
`endif

    assign out_free = !out_valid_q || w_ready_pe;
    assign out_hs   = out_valid_q && w_ready_pe;
    assign pix_left = (sent_q != count_q);
    // The first pixel may ride on the head handshake so head and body flits stream back to back.
    assign pix_ready = (state_q == StHead || state_q == StBody) && pix_left && out_free;
    assign pix_take  = pix_valid && pix_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        count_d     = count_q;
        sent_d      = sent_q;
        pkt_no_d    = pkt_no_q;
        done_d      = 1'b0;
`ifdef PE_PACKET_TX_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dst_x_d     = dst_x;
                    dst_y_d     = dst_y;
                    count_d     = pix_count;
                    sent_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = make_flit(dst_x, dst_y, pkt_no_q, FLIT_HEAD, head_data);
                    state_d     = StHead;
`ifdef PE_PACKET_TX_CHECKSUM_EN
                    acc_d       = '0;
`endif
                end
            end
            StHead, StBody: begin
                if (pix_take) begin
                    out_valid_d = 1'b1;
                    out_data_d  = make_flit(dst_x_q, dst_y_q, pkt_no_q, FLIT_BODY, pix_data);
                    sent_d      = sent_q + cnt_width'(1);
                    state_d     = StBody;
`ifdef PE_PACKET_TX_CHECKSUM_EN
                    acc_d       = acc_q + pix_data;
`endif
                end else if (!pix_left && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = make_flit(dst_x_q, dst_y_q, pkt_no_q, FLIT_TAIL, tail_payload);
                    state_d     = StTail;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                    state_d     = StBody;
                end
            end
            StTail: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    pkt_no_d    = pkt_no_q + pkt_no_field_size'(1);
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            count_q     <= '0;
            sent_q      <= '0;
            pkt_no_q    <= '0;
            done_q      <= 1'b0;
`ifdef PE_PACKET_TX_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            count_q     <= count_d;
            sent_q      <= sent_d;
            pkt_no_q    <= pkt_no_d;
            done_q      <= done_d;
`ifdef PE_PACKET_TX_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign w_valid_pe    = out_valid_q;
    assign w_data_pe     = out_data_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign state_monitor = state_q;

endmodule

// File: tb/tb_pe_packet_tx.sv
// Randomized bench for pe_packet_tx: packet-level flit scoreboard plus handshake rule checks.
module tb_pe_packet_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  dst_x, dst_y;
    logic [15:0] pix_count;
    logic [23:0] head_data;
    logic        pix_valid, pix_ready;
    logic [23:0] pix_data;
    logic        w_valid_pe, w_ready_pe;
    logic [33:0] w_data_pe;
    logic        busy, done;
    logic [1:0]  state_monitor;

    pe_packet_tx dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .dst_x         (dst_x),
        .dst_y         (dst_y),
        .pix_count     (pix_count),
        .head_data     (head_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .w_valid_pe    (w_valid_pe),
        .w_ready_pe    (w_ready_pe),
        .w_data_pe     (w_data_pe),
        .busy          (busy),
        .done          (done),
        .state_monitor (state_monitor)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flit = x*2^32 + y*2^30 + pkt*2^26 + id*2^24 + data
    function automatic logic [33:0] mk(input int x, input int y, input int p, input int id,
                                       input logic [23:0] d);
        logic [63:0] v;
        v = 64'(((x * 4 + y) * 16 + p) * 4 + id);
        return 34'((v << 24) + 64'(d));
    endfunction

    logic [33:0] exp_q[$];
    logic [23:0] pix_src[$];
    int          model_pkt = 0;
    int          head_seen = 0;
    int          hs_cnt, first_hs_cyc, last_hs_cyc;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_data;
    bit          tail_hs_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            prev_stall   = 0;
            tail_hs_prev = 0;
        end else begin
            check_eq("done_pulse", done, tail_hs_prev);
            if (prev_stall) check_eq("stall_hold", {w_valid_pe, w_data_pe}, {1'b1, prev_data});
            if (w_valid_pe && !w_ready_pe) check_eq("pix_rdy_stall", pix_ready, 0);
            tail_hs_prev = 0;
            if (w_valid_pe && w_ready_pe) begin
                if (exp_q.size() == 0) check_eq("flit_avail", exp_q.size(), 1);
                else check_eq("flit", w_data_pe, exp_q.pop_front());
                if (w_data_pe[25:24] == 2'b00) head_seen++;
                if (w_data_pe[25:24] == 2'b11) tail_hs_prev = 1;
                if (hs_cnt == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
            end
            prev_stall = w_valid_pe && !w_ready_pe;
            prev_data  = w_data_pe;
        end
    end

    task automatic drive_ready(input int rmode);
        if (rmode == 0) w_ready_pe = 1'b1;
        else if (rmode == 1) w_ready_pe = ~w_ready_pe;
        else w_ready_pe = 1'($urandom_range(0, 1));
    endtask

    // rmode: 0 ready always, 1 toggling, 2 random; vmode: 0 pixel always valid, 1 random.
    task automatic send_pkt(input int x, input int y, input logic [23:0] hd, input int rmode,
                            input int vmode, input int abort_after);
        int          n = pix_src.size();
        int          idx = 0;
        int          budget = 8 * n + 64;
        logic [23:0] sum = '0;
        bit          acc, seen_rdy = 0, finished = 0;

        exp_q.push_back(mk(x, y, model_pkt, 0, hd));
        foreach (pix_src[i]) begin
            exp_q.push_back(mk(x, y, model_pkt, 1, pix_src[i]));
            sum += pix_src[i];
        end
`ifdef PE_PACKET_TX_CHECKSUM_EN
        exp_q.push_back(mk(x, y, model_pkt, 3, sum));
`else
        exp_q.push_back(mk(x, y, model_pkt, 3, 24'(n)));
`endif
        hs_cnt = 0;

        @(posedge clk); #1;
        start = 1; dst_x = 2'(x); dst_y = 2'(y); pix_count = 16'(n); head_data = hd;
        drive_ready(rmode);
        @(posedge clk); #1;
        start = 0;
        dst_x = 2'($urandom); dst_y = 2'($urandom);
        pix_count = 16'($urandom); head_data = 24'($urandom);
        drive_ready(rmode);
        pix_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        pix_data  = (n > 0) ? pix_src[0] : 24'hDEAD00;
        @(negedge clk);
        check_eq("start_state", {busy, state_monitor}, {1'b1, 2'd1});

        forever begin
            if (idx == n) check_eq("pix_rdy_after_n", pix_ready, 0);
            if (pix_ready) seen_rdy = 1;
            acc = pix_valid && pix_ready;
            if (done) begin
                check_eq("idle_after", {busy, state_monitor}, 0);
                check_eq("flits_left", exp_q.size(), 0);
                finished = 1;
                break;
            end
            budget--;
            if (budget == 0) begin
                check_eq("timeout", done, 1);
                break;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (abort_after >= 0 && idx == abort_after) begin
                rstn = 0;
                #1;
                check_eq("abort_out", {w_valid_pe, busy, state_monitor, done}, 0);
                exp_q.delete();
                model_pkt = 0;
                start = 0; pix_valid = 0;
                repeat (2) @(posedge clk);
                #1 rstn = 1;
                return;
            end
            if ($urandom_range(0, 5) == 0 && busy && !done) begin
                start = 1; dst_x = 2'($urandom); dst_y = 2'($urandom);
                pix_count = 16'($urandom_range(0, 3)); head_data = 24'($urandom);
            end else begin
                start = 0;
            end
            drive_ready(rmode);
            pix_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pix_data  = (idx < n) ? pix_src[idx] : 24'hDEAD00;
            @(negedge clk);
        end
        start = 0; pix_valid = 0;
        if (n == 0) check_eq("pix_rdy_cnt0", seen_rdy, 0);
        if (finished && rmode == 0 && vmode == 0)
            check_eq("no_bubble", last_hs_cyc - first_hs_cyc, n + 1);
        model_pkt = (model_pkt + 1) % 16;
    endtask

    initial begin
        int heads0;
        rstn = 0; start = 0; dst_x = 0; dst_y = 0; pix_count = 0; head_data = 0;
        pix_valid = 0; pix_data = 0; w_ready_pe = 0;
        #1;
        check_eq("rst_out", {w_valid_pe, busy, done, state_monitor, pix_ready, w_data_pe}, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // Reference packet, full throughput then toggling ready
        pix_src = '{24'h010203, 24'h040506, 24'h070809};
        send_pkt(2, 1, 24'hFFAABB, 0, 0, -1);
        send_pkt(2, 1, 24'hFFAABB, 1, 0, -1);

        // Empty packet
        pix_src.delete();
        send_pkt(1, 2, 24'h123456, 2, 1, -1);

        // 17 back-to-back random packets, spurious starts while busy
        heads0 = head_seen;
        for (int p = 0; p < 17; p++) begin
            pix_src.delete();
            for (int i = 0; i < $urandom_range(0, 6); i++) pix_src.push_back(24'($urandom));
            send_pkt($urandom_range(0, 2), $urandom_range(0, 2), 24'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 1), -1);
        end
        check_eq("head_count", head_seen - heads0, 17);

        // Reset mid-body, then a fresh packet must restart at pkt_no 0
        pix_src = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
        send_pkt(0, 2, 24'hABCDEF, 0, 0, 2);
        pix_src = '{24'h0A0B0C};
        send_pkt(1, 1, 24'h00C0DE, 2, 1, -1);

        // Wrapping checksum case, then a full 273x182 image
        pix_src = '{24'hFFFFFF, 24'h000002};
        send_pkt(2, 2, 24'h000111, 0, 0, -1);
        pix_src.delete();
        for (int i = 0; i < 273 * 182; i++) pix_src.push_back(24'($urandom));
        send_pkt(1, 0, 24'h0F0F0F, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
